toggle_checker: RTL and testbench
=================================

Name: toggle_checker

Overview:
Receive-side checker for the single-bit toggle stream produced by the team's toggle flip-flop (Q inverts every CK edge). It samples the incoming bit and acquires lock after a run of consecutive toggles. While locked, it flags and counts missed toggles, and drops lock after repeated misses. It sits next to the toggle source as an on-chip self-check, so the bench does not have to verify the stream by eye.

Parameters:
LOCK_LEN, 4, number of consecutive observed toggles required to enter LOCKED (legal range 1..15)
UNLOCK_MISS, 2, number of consecutive missed toggles in LOCKED that return the block to ACQ (legal range 1..15)
CNT_W, 16, width of ERR_CNT; the counter saturates at 2^CNT_W-1

Ports:
CK  input  1  clock; all state changes on the rising edge
RB  input  1  asynchronous, active-low reset
EN  input  1  checker enable; level-sensitive
CLR  input  1  synchronous clear of ERR_CNT
D_IN  input  1  toggle stream under check; synchronous to CK
LOCK  output  1  high while in the LOCKED state
ERR  output  1  one-cycle pulse for each missed toggle detected while LOCKED
ERR_CNT  output  CNT_W  saturating count of missed toggles

Behaviour:
- Clocking and reset: one clock, CK. Reset RB is asynchronous and active-low.
- While RB=0: state=IDLE; LOCK=0, ERR=0, ERR_CNT=0; s0=s1=0; prime=0; run=0; miss=0. Outputs clear immediately, without waiting for an edge.
- Sampling: on every edge, s0<=D_IN and s1<=s0, in all states.
- Priming: prime is a 2-bit counter that increments on each edge after reset and saturates at 2.
- Event definitions: tog = (prime==2) & (s0!=s1). nog = (prime==2) & (s0==s1).
- Latency: a toggle on D_IN is observed 2 edges after it is presented.
- States (encoding: IDLE=2'b00, ACQ=2'b01, LOCKED=2'b10):
  - IDLE: run=0, miss=0. If EN=1 at an edge, go to ACQ.
  - ACQ: on tog, run<=run+1; when run==LOCK_LEN-1 and tog, go to LOCKED and set run<=0. On nog, run<=0 and stay in ACQ.
  - LOCKED: LOCK=1. On tog, miss<=0. On nog: ERR<=1 for exactly one cycle, ERR_CNT increments, miss<=miss+1. When miss==UNLOCK_MISS-1 and nog, go to ACQ with run=0 and miss=0. The ERR pulse and count for that final miss still occur.
- EN=0 in any state: go to IDLE at the next edge and LOCK falls. ERR_CNT holds its value. No ERR pulse is generated in IDLE or ACQ.
- LOCK is registered: it rises at the same edge the state becomes LOCKED.
- ERR_CNT saturation: at 2^CNT_W-1 the count holds, and ERR still pulses.
- CLR=1: ERR_CNT<=0 at the edge. If CLR and a miss occur at the same edge, CLR wins: ERR_CNT=0 and ERR still pulses.
- Locking lag: with EN first sampled 1 at edge k, a stream already toggling, and prime==2, LOCK=1 after edge k+LOCK_LEN.
- Reset mid-operation: asynchronous return to the full reset state. Priming restarts, so the first 2 edges after release produce no tog or nog.

Decomposition:
- Package toggle_checker_pkg: state encoding constants (IDLE, ACQ, LOCKED), the parameter defaults, and the prime-done value (2).
- Sub-module sat_counter (parameter W; inputs CK, RB, clr, inc; output q) implements ERR_CNT with clear priority and saturation.
- The FSM, sampling registers, run/miss counters and ERR register stay in toggle_checker.

Test Plan:
- Reset and priming: hold RB=0 for 3 cycles, then EN=1 with D_IN toggling every cycle. LOCK=0 throughout reset; LOCK=1 exactly 4 edges after EN is first sampled (prime already 2); ERR and ERR_CNT stay 0.
- Single miss: once LOCKED, hold D_IN for one extra cycle. ERR=1 for exactly one cycle, 2 edges later; ERR_CNT=1; LOCK stays 1.
- Unlock: hold D_IN constant for 3 cycles while LOCKED. Two ERR pulses, ERR_CNT=2, state returns to ACQ, LOCK=0. Resume toggling: LOCK returns after 4 toggles.
- Enable and clear: drop EN while LOCKED, then LOCK=0 at the next edge and ERR_CNT holds. Assert CLR in the same cycle as a miss: ERR pulses and ERR_CNT=0.
- Saturation: with CNT_W=2, cause 5 misses while LOCKED (toggle between misses to keep lock). ERR_CNT sequence is 1,2,3,3,3 and ERR pulses 5 times.
- Asynchronous reset mid-LOCKED: drop RB between edges. LOCK, ERR and ERR_CNT go to 0 without a CK edge; after release, the first 2 edges produce no events.

Source files
------------

// File: rtl/toggle_checker_pkg.sv
// toggle_checker_pkg
//   Shared definitions for the toggle stream checker: FSM state encoding,
//   default parameter values and the priming threshold.
package toggle_checker_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACQ    = 2'b01,
    LOCKED = 2'b10
  } state_e;

  localparam int unsigned LOCK_LEN_DEF    = 4;
  localparam int unsigned UNLOCK_MISS_DEF = 2;
  localparam int unsigned CNT_W_DEF       = 16;

  // Sampling pipeline is valid once prime reaches this value.
  localparam logic [1:0] PRIME_DONE = 2'd2;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   Saturating up-counter with synchronous clear. Clear has priority over
//   increment; at all-ones the count holds.
// Ports:
//   CK  - clock (rising edge)
//   RB  - asynchronous active-low reset
//   clr - synchronous clear to zero
//   inc - increment request
//   q   - current count
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         CK,
  input  logic         RB,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge CK or negedge RB) begin
    if (!RB) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/toggle_checker.sv
// toggle_checker
//   Receive-side checker for a single-bit toggle stream. Samples D_IN through
//   a two-stage pipeline, acquires lock after LOCK_LEN consecutive toggles,
//   then flags and counts missed toggles; UNLOCK_MISS consecutive misses
//   drop back to acquisition.
// Ports:
//   CK      - clock (rising edge)
//   RB      - asynchronous active-low reset
//   EN      - checker enable (level); low forces IDLE at the next edge
//   CLR     - synchronous clear of ERR_CNT (wins over a same-edge miss)
//   D_IN    - toggle stream under check
//   LOCK    - high while LOCKED
//   ERR     - one-cycle pulse per miss detected while LOCKED
//   ERR_CNT - saturating count of misses
module toggle_checker
  import toggle_checker_pkg::*;
#(
  parameter int unsigned LOCK_LEN    = LOCK_LEN_DEF,
  parameter int unsigned UNLOCK_MISS = UNLOCK_MISS_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic             CK,
  input  logic             RB,
  input  logic             EN,
  input  logic             CLR,
  input  logic             D_IN,
  output logic             LOCK,
  output logic             ERR,
  output logic [CNT_W-1:0] ERR_CNT
);

  localparam logic [3:0] RUN_LAST  = 4'(LOCK_LEN - 1);
  localparam logic [3:0] MISS_LAST = 4'(UNLOCK_MISS - 1);

  state_e     state_q;
  logic       s0_q;
  logic       s1_q;
  logic [1:0] prime_q;
  logic [3:0] run_q;
  logic [3:0] miss_q;
  logic       lock_q;
  logic       err_q;

  logic prime_done;
  logic tog;
  logic nog;
  logic miss_inc;

  assign prime_done = (prime_q == PRIME_DONE);
  assign tog        = prime_done & (s0_q ^ s1_q);
  assign nog        = prime_done & ~(s0_q ^ s1_q);

  // Same condition that raises ERR, so the count and pulse stay aligned.
  assign miss_inc   = EN & (state_q == LOCKED) & nog;

  always_ff @(posedge CK or negedge RB) begin
    if (!RB) begin
      state_q <= IDLE;
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
      prime_q <= '0;
      run_q   <= '0;
      miss_q  <= '0;
      lock_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      s0_q  <= D_IN;
      s1_q  <= s0_q;
      err_q <= 1'b0;
      if (prime_q != PRIME_DONE) begin
        prime_q <= prime_q + 2'd1;
      end

      if (!EN) begin
        state_q <= IDLE;
        lock_q  <= 1'b0;
        run_q   <= '0;
        miss_q  <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            run_q   <= '0;
            miss_q  <= '0;
            state_q <= ACQ;
          end
          ACQ: begin
            if (tog) begin
              if (run_q == RUN_LAST) begin
                state_q <= LOCKED;
                lock_q  <= 1'b1;
                run_q   <= '0;
              end else begin
                run_q <= run_q + 4'd1;
              end
            end else if (nog) begin
              run_q <= '0;
            end
          end
          LOCKED: begin
            if (tog) begin
              miss_q <= '0;
            end else if (nog) begin
              err_q <= 1'b1;
              if (miss_q == MISS_LAST) begin
                state_q <= ACQ;
                lock_q  <= 1'b0;
                run_q   <= '0;
                miss_q  <= '0;
              end else begin
                miss_q <= miss_q + 4'd1;
              end
            end
          end
          default: begin
            state_q <= IDLE;
            lock_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_err_cnt (
    .CK (CK),
    .RB (RB),
    .clr(CLR),
    .inc(miss_inc),
    .q  (ERR_CNT)
  );

  assign LOCK = lock_q;
  assign ERR  = err_q;

endmodule

// File: tb/tb_toggle_checker.sv
// tb_toggle_checker
//   Directed bench for toggle_checker. Two instances share all inputs: one
//   with default parameters and one with a 2-bit error counter for the
//   saturation case. Inputs change 1 time unit after each rising edge and
//   outputs are sampled at that point.
module tb_toggle_checker;

  logic       CK;
  logic       RB;
  logic       EN;
  logic       CLR;
  logic       D_IN;
  logic       LOCK;
  logic       ERR;
  logic [15:0] ERR_CNT;
  logic       LOCK_s;
  logic       ERR_s;
  logic [1:0] CNT_s;

  int unsigned total;
  int unsigned bad;
  logic        dcur;

  toggle_checker #(
    .LOCK_LEN   (4),
    .UNLOCK_MISS(2),
    .CNT_W      (16)
  ) dut (
    .CK     (CK),
    .RB     (RB),
    .EN     (EN),
    .CLR    (CLR),
    .D_IN   (D_IN),
    .LOCK   (LOCK),
    .ERR    (ERR),
    .ERR_CNT(ERR_CNT)
  );

  toggle_checker #(
    .LOCK_LEN   (4),
    .UNLOCK_MISS(2),
    .CNT_W      (2)
  ) dut_s (
    .CK     (CK),
    .RB     (RB),
    .EN     (EN),
    .CLR    (CLR),
    .D_IN   (D_IN),
    .LOCK   (LOCK_s),
    .ERR    (ERR_s),
    .ERR_CNT(CNT_s)
  );

  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic d, input logic en, input logic clr);
    D_IN = d;
    EN   = en;
    CLR  = clr;
    @(posedge CK);
    #1;
  endtask

  // Present the inverse of the previous bit.
  task automatic tg(input logic en, input logic clr);
    dcur = ~dcur;
    step(dcur, en, clr);
  endtask

  // Present the same bit again.
  task automatic hd(input logic en, input logic clr);
    step(dcur, en, clr);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    dcur  = 1'b0;
    RB    = 1'b0;
    EN    = 1'b0;
    CLR   = 1'b0;
    D_IN  = 1'b0;

    // Reset held for 3 edges
    for (int i = 0; i < 3; i++) begin
      @(posedge CK);
      #1;
      check("rst_lock", {15'd0, LOCK}, 16'd0);
      check("rst_err", {15'd0, ERR}, 16'd0);
      check("rst_cnt", ERR_CNT, 16'd0);
    end
    RB = 1'b1;

    // Priming with EN low, stream already toggling
    for (int i = 0; i < 3; i++) begin
      tg(1'b0, 1'b0);
      check("prime_lock", {15'd0, LOCK}, 16'd0);
    end

    // Lock exactly 4 edges after EN is first sampled
    for (int i = 0; i < 5; i++) begin
      tg(1'b1, 1'b0);
      check("acq_lock", {15'd0, LOCK}, (i == 4) ? 16'd1 : 16'd0);
      check("acq_err", {15'd0, ERR}, 16'd0);
    end
    check("acq_cnt", ERR_CNT, 16'd0);

    // Single miss
    hd(1'b1, 1'b0);
    check("miss1_pre_err", {15'd0, ERR}, 16'd0);
    tg(1'b1, 1'b0);
    check("miss1_err", {15'd0, ERR}, 16'd1);
    check("miss1_cnt", ERR_CNT, 16'd1);
    check("miss1_lock", {15'd0, LOCK}, 16'd1);
    tg(1'b1, 1'b0);
    check("miss1_post_err", {15'd0, ERR}, 16'd0);
    check("miss1_post_lock", {15'd0, LOCK}, 16'd1);
    check("miss1_post_cnt", ERR_CNT, 16'd1);
    check("miss1_cnt_s", {14'd0, CNT_s}, 16'd1);

    // Three identical bits while locked: two misses, unlock
    hd(1'b1, 1'b0);
    check("unl_a_err", {15'd0, ERR}, 16'd0);
    check("unl_a_lock", {15'd0, LOCK}, 16'd1);
    hd(1'b1, 1'b0);
    check("unl_b_err", {15'd0, ERR}, 16'd1);
    check("unl_b_cnt", ERR_CNT, 16'd2);
    check("unl_b_lock", {15'd0, LOCK}, 16'd1);
    hd(1'b1, 1'b0);
    check("unl_c_err", {15'd0, ERR}, 16'd1);
    check("unl_c_cnt", ERR_CNT, 16'd3);
    check("unl_c_lock", {15'd0, LOCK}, 16'd0);
    check("unl_c_cnt_s", {14'd0, CNT_s}, 16'd3);
    tg(1'b1, 1'b0);
    check("unl_d_err", {15'd0, ERR}, 16'd0);
    check("unl_d_lock", {15'd0, LOCK}, 16'd0);
    for (int i = 0; i < 4; i++) begin
      tg(1'b1, 1'b0);
      check("relock", {15'd0, LOCK}, (i == 3) ? 16'd1 : 16'd0);
    end

    // Drop EN while locked
    tg(1'b0, 1'b0);
    check("en_off_lock", {15'd0, LOCK}, 16'd0);
    check("en_off_cnt", ERR_CNT, 16'd3);
    for (int i = 0; i < 5; i++) begin
      tg(1'b1, 1'b0);
      check("en_on_lock", {15'd0, LOCK}, (i == 4) ? 16'd1 : 16'd0);
    end

    // CLR coincident with a miss
    hd(1'b1, 1'b0);
    check("clr_pre_err", {15'd0, ERR}, 16'd0);
    tg(1'b1, 1'b1);
    check("clr_err", {15'd0, ERR}, 16'd1);
    check("clr_cnt", ERR_CNT, 16'd0);
    check("clr_cnt_s", {14'd0, CNT_s}, 16'd0);
    check("clr_lock", {15'd0, LOCK}, 16'd1);
    tg(1'b1, 1'b0);
    check("clr_post_err", {15'd0, ERR}, 16'd0);
    check("clr_post_cnt", ERR_CNT, 16'd0);

    // Five isolated misses: 2-bit counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      hd(1'b1, 1'b0);
      check("sat_gap_err", {15'd0, ERR_s}, 16'd0);
      tg(1'b1, 1'b0);
      check("sat_err_s", {15'd0, ERR_s}, 16'd1);
      check("sat_cnt_s", {14'd0, CNT_s}, (i < 3) ? 16'(i + 1) : 16'd3);
      check("sat_cnt", ERR_CNT, 16'(i + 1));
      check("sat_lock_s", {15'd0, LOCK_s}, 16'd1);
    end

    // Asynchronous reset between edges while locked with ERR high
    #2;
    RB = 1'b0;
    #1;
    check("arst_lock", {15'd0, LOCK}, 16'd0);
    check("arst_err", {15'd0, ERR}, 16'd0);
    check("arst_cnt", ERR_CNT, 16'd0);
    check("arst_cnt_s", {14'd0, CNT_s}, 16'd0);
    @(posedge CK);
    #1;
    RB = 1'b1;

    // Priming restarts: lock needs 6 edges from release with EN high
    for (int i = 0; i < 6; i++) begin
      tg(1'b1, 1'b0);
      check("post_rst_lock", {15'd0, LOCK}, (i == 5) ? 16'd1 : 16'd0);
      check("post_rst_err", {15'd0, ERR}, 16'd0);
    end
    check("post_rst_cnt", ERR_CNT, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
